counter_monitor: RTL and testbench

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_monitor.sv | 147 ++++++++++++++
 tb/tb_counter_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Watches an 8-bit counter and its complement companion: classifies each accepted
// step, keeps saturating step/wrap/jump statistics, a sticky integrity flag and a threshold alarm.
//
// state | meaning
// INIT  | no reference sample yet; next good sample loads prev only
// TRACK | prev holds the last good sample; good samples are classified against it
module counter_monitor (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  input  logic [7:0]  value_inv,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  thresh_hi,
  input  logic [7:0]  thresh_lo,
  output logic [1:0]  dir,
  output logic        wrap_pulse,
  output logic [15:0] step_cnt,
  output logic [7:0]  wrap_cnt,
  output logic [7:0]  jump_cnt,
  output logic        err,
  output logic        alarm
);

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_JUMP = 2'b11;

  state_t      state, state_nxt;
  logic [7:0]  prev, prev_nxt;
  logic [1:0]  dir_nxt;
  logic        wrap_pulse_nxt;
  logic [15:0] step_cnt_nxt;
  logic [7:0]  wrap_cnt_nxt;
  logic [7:0]  jump_cnt_nxt;
  logic        err_nxt;
  logic        alarm_nxt;

  logic        good;
  logic [7:0]  delta;
  logic        is_wrap;
  logic        alarm_eval;

  assign good    = (value_inv == ~value);
  assign delta   = value - prev;
  assign is_wrap = ((prev == 8'hFF) && (value == 8'h00)) ||
                   ((prev == 8'h00) && (value == 8'hFF));

  // Set wins over release when the thresholds overlap.
  always_comb begin
    alarm_eval = alarm;
    if (value >= thresh_hi) begin
      alarm_eval = 1'b1;
    end else if (value <= thresh_lo) begin
      alarm_eval = 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    dir_nxt        = dir;
    wrap_pulse_nxt = 1'b0;
    step_cnt_nxt   = step_cnt;
    wrap_cnt_nxt   = wrap_cnt;
    jump_cnt_nxt   = jump_cnt;
    err_nxt        = err;
    alarm_nxt      = alarm;

    if (clr) begin
      state_nxt    = INIT;
      prev_nxt     = 8'h00;
      dir_nxt      = DIR_HOLD;
      step_cnt_nxt = 16'h0000;
      wrap_cnt_nxt = 8'h00;
      jump_cnt_nxt = 8'h00;
      err_nxt      = 1'b0;
      alarm_nxt    = 1'b0;
    end else if (en) begin
      if (!good) begin
        err_nxt = 1'b1;
      end else begin
        prev_nxt  = value;
        alarm_nxt = alarm_eval;
        case (state)
          INIT: begin
            dir_nxt   = DIR_HOLD;
            state_nxt = TRACK;
          end
          TRACK: begin
            case (delta)
              8'h00: dir_nxt = DIR_HOLD;
              8'h01: begin
                dir_nxt = DIR_UP;
                if (step_cnt != 16'hFFFF) step_cnt_nxt = step_cnt + 16'd1;
              end
              8'hFF: begin
                dir_nxt = DIR_DOWN;
                if (step_cnt != 16'hFFFF) step_cnt_nxt = step_cnt + 16'd1;
              end
              default: begin
                dir_nxt = DIR_JUMP;
                if (jump_cnt != 8'hFF) jump_cnt_nxt = jump_cnt + 8'd1;
              end
            endcase
            if (is_wrap) begin
              wrap_pulse_nxt = 1'b1;
              if (wrap_cnt != 8'hFF) wrap_cnt_nxt = wrap_cnt + 8'd1;
            end
          end
          default: state_nxt = INIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      prev       <= 8'h00;
      dir        <= DIR_HOLD;
      wrap_pulse <= 1'b0;
      step_cnt   <= 16'h0000;
      wrap_cnt   <= 8'h00;
      jump_cnt   <= 8'h00;
      err        <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      dir        <= dir_nxt;
      wrap_pulse <= wrap_pulse_nxt;
      step_cnt   <= step_cnt_nxt;
      wrap_cnt   <= wrap_cnt_nxt;
      jump_cnt   <= jump_cnt_nxt;
      err        <= err_nxt;
      alarm      <= alarm_nxt;
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench for counter_monitor: directed vector table, hand sequences for
// alarm hysteresis, saturation, clear and async reset, then randomized traffic vs a reference model.
module tb_counter_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  value, value_inv, thresh_hi, thresh_lo;
  logic        en, clr;
  logic [1:0]  dir;
  logic        wrap_pulse, err, alarm;
  logic [15:0] step_cnt;
  logic [7:0]  wrap_cnt, jump_cnt;

  int checks = 0;
  int errors = 0;

  counter_monitor dut (
    .clk(clk), .rst(rst), .value(value), .value_inv(value_inv), .en(en), .clr(clr),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .dir(dir), .wrap_pulse(wrap_pulse),
    .step_cnt(step_cnt), .wrap_cnt(wrap_cnt), .jump_cnt(jump_cnt), .err(err), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic over the stated rules.
  bit m_have;
  int m_prev, m_dir, m_wp, m_step, m_wrap, m_jump, m_err, m_alarm;

  function automatic int sat_inc(input int x, input int maxv);
    return (x >= maxv) ? maxv : x + 1;
  endfunction

  task automatic m_reset();
    m_have = 0; m_prev = 0; m_dir = 0; m_wp = 0;
    m_step = 0; m_wrap = 0; m_jump = 0; m_err = 0; m_alarm = 0;
  endtask

  task automatic m_step_fn(input int v, input int iv, input bit e, input bit c);
    int d;
    if (c) begin
      m_reset();
      return;
    end
    m_wp = 0;
    if (!e) return;
    if (iv != (255 - v)) begin
      m_err = 1;
      return;
    end
    if (m_have) begin
      d = (v - m_prev + 256) % 256;
      if (d == 0) m_dir = 0;
      else if (d == 1) begin m_dir = 1; m_step = sat_inc(m_step, 65535); end
      else if (d == 255) begin m_dir = 2; m_step = sat_inc(m_step, 65535); end
      else begin m_dir = 3; m_jump = sat_inc(m_jump, 255); end
      if ((m_prev == 255 && v == 0) || (m_prev == 0 && v == 255)) begin
        m_wp = 1;
        m_wrap = sat_inc(m_wrap, 255);
      end
    end else begin
      m_dir = 0;
      m_have = 1;
    end
    m_prev = v;
    if (v >= int'(thresh_hi)) m_alarm = 1;
    else if (v <= int'(thresh_lo)) m_alarm = 0;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".dir"},        int'(dir),        m_dir);
    check({tag, ".wrap_pulse"}, int'(wrap_pulse), m_wp);
    check({tag, ".step_cnt"},   int'(step_cnt),   m_step);
    check({tag, ".wrap_cnt"},   int'(wrap_cnt),   m_wrap);
    check({tag, ".jump_cnt"},   int'(jump_cnt),   m_jump);
    check({tag, ".err"},        int'(err),        m_err);
    check({tag, ".alarm"},      int'(alarm),      m_alarm);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".dir"},        int'(dir),        0);
    check({tag, ".wrap_pulse"}, int'(wrap_pulse), 0);
    check({tag, ".step_cnt"},   int'(step_cnt),   0);
    check({tag, ".wrap_cnt"},   int'(wrap_cnt),   0);
    check({tag, ".jump_cnt"},   int'(jump_cnt),   0);
    check({tag, ".err"},        int'(err),        0);
    check({tag, ".alarm"},      int'(alarm),      0);
  endtask

  task automatic cyc(input logic [7:0] v, input logic [7:0] iv, input logic e, input logic c,
                     input bit chk);
    value = v; value_inv = iv; en = e; clr = c;
    m_step_fn(int'(v), int'(iv), e, c);
    @(posedge clk);
    #1;
    if (chk) check_model("model");
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    check_zero(tag);
    m_reset();
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]  v;
    logic        good;
    logic        e;
    logic        c;
    logic [1:0]  dir;
    logic        wp;
    logic [15:0] step;
    logic [7:0]  wrap;
    logic [7:0]  jump;
    logic        err;
    logic        alarm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] v, input logic good, input logic e, input logic c,
                              input logic [1:0] d, input logic wp, input logic [15:0] s,
                              input logic [7:0] w, input logic [7:0] j, input logic er,
                              input logic al);
    vecs.push_back('{v, good, e, c, d, wp, s, w, j, er, al});
  endfunction

  initial begin
    logic [7:0] v, iv;
    int r;

    // thresh_hi=A0, thresh_lo=90 for the table
    add(8'h32,1,1,0, 2'd0,0, 16'd0, 8'd0,8'd0, 0,0);
    add(8'h33,1,1,0, 2'd1,0, 16'd1, 8'd0,8'd0, 0,0);
    add(8'h34,1,1,0, 2'd1,0, 16'd2, 8'd0,8'd0, 0,0);
    add(8'h35,1,1,0, 2'd1,0, 16'd3, 8'd0,8'd0, 0,0);
    add(8'h77,1,1,1, 2'd0,0, 16'd0, 8'd0,8'd0, 0,0);
    add(8'h01,1,1,0, 2'd0,0, 16'd0, 8'd0,8'd0, 0,0);
    add(8'h00,1,1,0, 2'd2,0, 16'd1, 8'd0,8'd0, 0,0);
    add(8'hFF,1,1,0, 2'd2,1, 16'd2, 8'd1,8'd0, 0,1);
    add(8'hFE,1,1,0, 2'd2,0, 16'd3, 8'd1,8'd0, 0,1);
    add(8'h00,1,0,0, 2'd2,0, 16'd3, 8'd1,8'd0, 0,1);
    add(8'h40,1,1,0, 2'd3,0, 16'd3, 8'd1,8'd1, 0,0);
    add(8'hC8,1,1,0, 2'd3,0, 16'd3, 8'd1,8'd2, 0,1);
    add(8'hC8,1,1,0, 2'd0,0, 16'd3, 8'd1,8'd2, 0,1);
    add(8'h10,0,1,0, 2'd0,0, 16'd3, 8'd1,8'd2, 1,1);
    add(8'hC9,1,1,0, 2'd1,0, 16'd4, 8'd1,8'd2, 1,1);
    add(8'h80,1,1,0, 2'd3,0, 16'd4, 8'd1,8'd3, 1,0);
    add(8'h9E,1,1,0, 2'd3,0, 16'd4, 8'd1,8'd4, 1,0);
    add(8'h9F,1,1,0, 2'd1,0, 16'd5, 8'd1,8'd4, 1,0);
    add(8'hA0,1,1,0, 2'd1,0, 16'd6, 8'd1,8'd4, 1,1);
    add(8'hA1,1,1,0, 2'd1,0, 16'd7, 8'd1,8'd4, 1,1);
    add(8'hA2,1,1,0, 2'd1,0, 16'd8, 8'd1,8'd4, 1,1);
    add(8'hFF,1,1,0, 2'd3,0, 16'd8, 8'd1,8'd5, 1,1);
    add(8'h00,1,1,0, 2'd1,1, 16'd9, 8'd2,8'd5, 1,0);
    add(8'h01,1,1,0, 2'd1,0, 16'd10,8'd2,8'd5, 1,0);

    rst = 1'b1; en = 1'b0; clr = 1'b0; value = 8'h00; value_inv = 8'hFF;
    thresh_hi = 8'hA0; thresh_lo = 8'h90;
    m_reset();
    #12;
    check_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      v  = vecs[i].v;
      iv = vecs[i].good ? ~v : 8'h00;
      cyc(v, iv, vecs[i].e, vecs[i].c, 1'b1);
      check($sformatf("vec%0d.dir", i),   int'(dir),        int'(vecs[i].dir));
      check($sformatf("vec%0d.wp", i),    int'(wrap_pulse), int'(vecs[i].wp));
      check($sformatf("vec%0d.step", i),  int'(step_cnt),   int'(vecs[i].step));
      check($sformatf("vec%0d.wrap", i),  int'(wrap_cnt),   int'(vecs[i].wrap));
      check($sformatf("vec%0d.jump", i),  int'(jump_cnt),   int'(vecs[i].jump));
      check($sformatf("vec%0d.err", i),   int'(err),        int'(vecs[i].err));
      check($sformatf("vec%0d.alarm", i), int'(alarm),      int'(vecs[i].alarm));
    end

    // Hysteresis: set at A2, ramp down through the band, release only at 90.
    cyc(8'hA2, 8'h5D, 1'b1, 1'b0, 1'b1);
    check("hyst.set", int'(alarm), 1);
    for (int x = 8'hA1; x >= 8'h91; x--) begin
      v = 8'(x);
      cyc(v, ~v, 1'b1, 1'b0, 1'b1);
      check($sformatf("hyst.hold_%0h", x), int'(alarm), 1);
    end
    cyc(8'h90, 8'h6F, 1'b1, 1'b0, 1'b1);
    check("hyst.release", int'(alarm), 0);

    // wrap_pulse lasts one cycle even with en low.
    cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    cyc(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    check("wp.assert", int'(wrap_pulse), 1);
    cyc(8'h12, 8'hED, 1'b0, 1'b0, 1'b1);
    check("wp.deassert_en0", int'(wrap_pulse), 0);

    // Saturation: clear, then one INIT sample plus 65540 up steps.
    cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i <= 65540; i++) begin
      v = 8'(i);
      cyc(v, ~v, 1'b1, 1'b0, (i % 4096) == 0);
    end
    check("sat.step_cnt", int'(step_cnt), 16'hFFFF);
    check("sat.wrap_cnt", int'(wrap_cnt), 8'hFF);
    check_model("sat");

    // clr beats en; the concurrent sample is discarded and FSM is back in INIT.
    cyc(8'h20, 8'hDF, 1'b1, 1'b1, 1'b1);
    check_zero("clr");
    cyc(8'h55, 8'hAA, 1'b1, 1'b0, 1'b1);
    check("clr.init_dir", int'(dir), 0);
    check("clr.init_step", int'(step_cnt), 0);
    cyc(8'h57, 8'hA8, 1'b1, 1'b0, 1'b1);
    check("clr.track_jump", int'(jump_cnt), 1);

    // Async reset mid-operation, then first good sample is treated as INIT.
    cyc(8'h58, 8'h00, 1'b1, 1'b0, 1'b1);
    async_reset("rst_async");
    cyc(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    check("rst.init_dir", int'(dir), 0);
    check("rst.init_wp", int'(wrap_pulse), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        thresh_hi = 8'($urandom_range(0, 255));
        thresh_lo = 8'($urandom_range(0, 255));
      end
      r = int'($urandom_range(0, 9));
      if (r <= 5) v = 8'(m_prev + int'($urandom_range(0, 2)) - 1);
      else if (r == 6) v = 8'h00;
      else if (r == 7) v = 8'hFF;
      else v = 8'($urandom_range(0, 255));
      iv = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : ~v;
      cyc(v, iv, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, 1'b1);
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
